// File: rtl/line_window_ctrl.sv
// Line-buffer sequencer: feeds a shift_taps buffer from a raster stream and qualifies its taps as vertical windows.
// Optional statistics (frame_cnt, err_restart) are enabled by defining LINE_WINDOW_CTRL_STATS_EN.
module line_window_ctrl #(
    parameter int width      = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WIN_ROWS   = 3,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [width-1:0] s_data,
    input  logic             s_sof,
    output logic             lb_clken,
    output logic [width-1:0] lb_shiftin,
    output logic             lb_sclr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [COL_W-1:0] m_col,
    output logic [ROW_W-1:0] m_row,
    output logic             m_sol,
    output logic             m_eol,
    output logic             m_eof,
    output logic             busy
`ifdef LINE_WINDOW_CTRL_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic             err_restart
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] FILL_LAST_ROW = ROW_W'(WIN_ROWS - 2);

    state_t           state_r;
    state_t           state_next_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_next_s;
    logic [COL_W-1:0] col_adv_s;
    logic [ROW_W-1:0] row_r;
    logic [ROW_W-1:0] row_next_s;
    logic [ROW_W-1:0] row_adv_s;
    logic             accept_s;
    logic             clken_s;
    logic             restart_s;
    logic             emit_s;
    logic             line_end_s;
    logic             frame_end_s;

    // Input handshake: a shift is only allowed once any pending window has been taken.
    always_comb begin
        s_ready     = (state_r != DONE) & (~m_valid | m_ready);
        accept_s    = s_valid & s_ready;
        line_end_s  = (col_r == COL_LAST);
        frame_end_s = line_end_s & (row_r == ROW_LAST);
        restart_s   = accept_s & s_sof & ((state_r == FILL) | (state_r == RUN));
        emit_s      = accept_s & ~s_sof & (state_r == RUN);
    end

    // Raster position of the pixel following the one currently accepted.
    always_comb begin
        col_adv_s = col_r + COL_W'(1);
        row_adv_s = row_r;
        if (line_end_s) begin
            col_adv_s = {COL_W{1'b0}};
            row_adv_s = row_r + ROW_W'(1);
        end else begin
            col_adv_s = col_r + COL_W'(1);
        end
    end

    // Next-state and buffer-enable logic; an s_sof pixel inside a frame restarts it at (0,0).
    always_comb begin
        state_next_s = state_r;
        col_next_s   = col_r;
        row_next_s   = row_r;
        clken_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && s_sof) begin
                    clken_s      = 1'b1;
                    state_next_s = FILL;
                    col_next_s   = COL_W'(1);
                    row_next_s   = {ROW_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    clken_s = 1'b1;
                    if (s_sof) begin
                        state_next_s = FILL;
                        col_next_s   = COL_W'(1);
                        row_next_s   = {ROW_W{1'b0}};
                    end else begin
                        col_next_s = col_adv_s;
                        row_next_s = row_adv_s;
                        if (line_end_s && (row_r == FILL_LAST_ROW)) begin
                            state_next_s = RUN;
                        end else begin
                            state_next_s = FILL;
                        end
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            RUN: begin
                if (accept_s) begin
                    clken_s = 1'b1;
                    if (s_sof) begin
                        state_next_s = FILL;
                        col_next_s   = COL_W'(1);
                        row_next_s   = {ROW_W{1'b0}};
                    end else if (frame_end_s) begin
                        state_next_s = DONE;
                        col_next_s   = {COL_W{1'b0}};
                        row_next_s   = {ROW_W{1'b0}};
                    end else begin
                        col_next_s = col_adv_s;
                        row_next_s = row_adv_s;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                col_next_s   = {COL_W{1'b0}};
                row_next_s   = {ROW_W{1'b0}};
            end
        endcase
    end

    // Buffer-side controls; reset also clears the buffer and blocks any shift.
    always_comb begin
        lb_clken   = clken_s & ~sclr;
        lb_sclr    = sclr | restart_s;
        lb_shiftin = s_data;
        busy       = (state_r != IDLE);
    end

    // State and raster counters.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_r <= IDLE;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            col_r   <= col_next_s;
            row_r   <= row_next_s;
        end
    end

    // Window qualifier; registered on the accept edge so it lines up with the updated taps.
    always_ff @(posedge clock) begin
        if (sclr) begin
            m_valid <= 1'b0;
            m_col   <= {COL_W{1'b0}};
            m_row   <= {ROW_W{1'b0}};
            m_sol   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (emit_s) begin
            m_valid <= 1'b1;
            m_col   <= col_r;
            m_row   <= row_r;
            m_sol   <= (col_r == {COL_W{1'b0}});
            m_eol   <= line_end_s;
            m_eof   <= frame_end_s;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end else begin
            m_valid <= m_valid;
        end
    end

`ifdef LINE_WINDOW_CTRL_STATS_EN
    // Frame counter and sticky restart flag.
    always_ff @(posedge clock) begin
        if (sclr) begin
            frame_cnt   <= 16'd0;
            err_restart <= 1'b0;
        end else begin
            if (emit_s && frame_end_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (restart_s) begin
                err_restart <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl on a 4x4 image with 3-row windows.
// Statistics ports are exercised when LINE_WINDOW_CTRL_STATS_EN is defined.
module tb_line_window_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WR = 3;

    logic       clk = 1'b0;
    logic       sclr, s_valid, s_ready, s_sof, lb_clken, lb_sclr;
    logic [7:0] s_data, lb_shiftin;
    logic       m_valid, m_ready, m_sol, m_eol, m_eof, busy;
    logic [1:0] m_col, m_row;
`ifdef LINE_WINDOW_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic        err_restart;
`endif

    int checks = 0;
    int errors = 0;

    line_window_ctrl #(
        .width(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .WIN_ROWS(WR), .COL_W(2), .ROW_W(2)
    ) dut (
        .clock(clk), .sclr(sclr), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .lb_clken(lb_clken), .lb_shiftin(lb_shiftin), .lb_sclr(lb_sclr),
        .m_valid(m_valid), .m_ready(m_ready), .m_col(m_col), .m_row(m_row), .m_sol(m_sol),
        .m_eol(m_eol), .m_eof(m_eof), .busy(busy)
`ifdef LINE_WINDOW_CTRL_STATS_EN
        , .frame_cnt(frame_cnt), .err_restart(err_restart)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a count of accepted pixels since s_sof.
    bit md_in_frame, md_done, md_pend, last_acc;
    int md_n, frames, hs_cnt;
    bit errst;
    int mw_col, mw_row, mw_sol, mw_eol, mw_eof;

    task automatic model_reset();
        md_in_frame = 0; md_done = 0; md_pend = 0; md_n = 0; frames = 0; errst = 0;
    endtask

    task automatic cyc(input bit rs, input bit sv, input bit sof, input logic [7:0] d, input bit mr);
        bit exp_ready, acc, newwin;
        int idx;
        sclr = rs; s_valid = sv; s_sof = sof; s_data = d; m_ready = mr;
        #1;
        exp_ready = !md_done && (!md_pend || mr);
        acc       = sv && exp_ready;
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("lb_clken", 32'(lb_clken), 32'(!rs && acc && (md_in_frame || sof)));
        chk("lb_sclr", 32'(lb_sclr), 32'(rs || (acc && sof && md_in_frame)));
        chk("lb_shiftin", 32'(lb_shiftin), 32'(d));
        chk("busy", 32'(busy), 32'(md_in_frame || md_done));
        chk("m_valid", 32'(m_valid), 32'(md_pend));
        if (md_pend) begin
            chk("m_col", 32'(m_col), 32'(mw_col));
            chk("m_row", 32'(m_row), 32'(mw_row));
            chk("m_sol", 32'(m_sol), 32'(mw_sol));
            chk("m_eol", 32'(m_eol), 32'(mw_eol));
            chk("m_eof", 32'(m_eof), 32'(mw_eof));
        end
`ifdef LINE_WINDOW_CTRL_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(frames[15:0]));
        chk("err_restart", 32'(err_restart), 32'(errst));
`endif
        if (m_valid && mr) hs_cnt++;
        last_acc = acc && !rs;
        if (rs) begin
            model_reset();
        end else begin
            newwin = 0;
            md_done = 0;
            if (acc) begin
                if (sof) begin
                    if (md_in_frame) errst = 1;
                    md_in_frame = 1;
                    md_n = 1;
                end else if (md_in_frame) begin
                    idx = md_n;
                    md_n++;
                    if (idx >= (WR - 1) * W) begin
                        newwin = 1;
                        mw_col = idx % W;
                        mw_row = idx / W;
                        mw_sol = (mw_col == 0);
                        mw_eol = (mw_col == W - 1);
                        mw_eof = (idx == W * H - 1);
                    end
                    if (idx == W * H - 1) begin
                        md_in_frame = 0;
                        md_done = 1;
                        frames++;
                    end
                end
            end
            if (newwin) md_pend = 1;
            else if (mr) md_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int px, input bit sof);
        int guard;
        guard = 0;
        last_acc = 0;
        while (!last_acc && guard < 20) begin
            cyc(1'b0, 1'b1, sof, 8'(px), 1'b1);
            guard++;
        end
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixel=%0d not accepted within 20 cycles", px);
        end
    endtask

    task automatic flush();
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    typedef struct {
        bit rs, sv, sof;
        int d;
        bit e_rdy, e_clk, e_lbs, e_mv;
        int e_col, e_row;
        bit e_sol, e_eol, e_eof, e_busy;
    } vec_t;

    function automatic vec_t mkv(bit rs, bit sv, bit sof, int d, bit rdy, bit clk_e, bit lbs,
                                 bit mv, int col, int row, bit sol, bit eol, bit eof, bit bsy);
        vec_t v;
        v.rs = rs; v.sv = sv; v.sof = sof; v.d = d;
        v.e_rdy = rdy; v.e_clk = clk_e; v.e_lbs = lbs; v.e_mv = mv;
        v.e_col = col; v.e_row = row; v.e_sol = sol; v.e_eol = eol; v.e_eof = eof; v.e_busy = bsy;
        return v;
    endfunction

    vec_t tbl[24];
    int   hs0;

    initial begin
        // Reset, five dropped pixels, then one full frame with m_ready held high.
        tbl[0] = mkv(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) tbl[i] = mkv(0, 1, 0, 100 + i, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6] = mkv(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            int p;
            p = k - 1;
            tbl[6 + k] = mkv(0, 1, 0, k, 1, 1, 0, p >= 8, p % W, p / W, (p % W) == 0,
                             (p % W) == W - 1, p == W * H - 1, 1);
        end
        tbl[22] = mkv(0, 1, 0, 0, 0, 0, 0, 1, 3, 3, 0, 1, 1, 1);
        tbl[23] = mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        sclr = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        hs_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            sclr = tbl[i].rs; s_valid = tbl[i].sv; s_sof = tbl[i].sof;
            s_data = 8'(tbl[i].d); m_ready = 1'b1;
            #1;
            chk("t_s_ready", 32'(s_ready), 32'(tbl[i].e_rdy));
            chk("t_lb_clken", 32'(lb_clken), 32'(tbl[i].e_clk));
            chk("t_lb_sclr", 32'(lb_sclr), 32'(tbl[i].e_lbs));
            chk("t_m_valid", 32'(m_valid), 32'(tbl[i].e_mv));
            chk("t_busy", 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_mv) begin
                chk("t_m_col", 32'(m_col), 32'(tbl[i].e_col));
                chk("t_m_row", 32'(m_row), 32'(tbl[i].e_row));
                chk("t_m_sol", 32'(m_sol), 32'(tbl[i].e_sol));
                chk("t_m_eol", 32'(m_eol), 32'(tbl[i].e_eol));
                chk("t_m_eof", 32'(m_eof), 32'(tbl[i].e_eof));
            end
            @(posedge clk);
            #1;
        end
        model_reset();
        frames = 1;

        // Output backpressure after the first window: nothing shifts, nothing is lost.
        hs0 = hs_cnt;
        send(0, 1'b1);
        for (int px = 1; px <= 8; px++) send(px, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 8'd9, 1'b0);
        for (int px = 9; px <= 15; px++) send(px, 1'b0);
        flush();
        chk("bp_windows", 32'(hs_cnt - hs0), 32'd8);

        // Restart inside RUN: next window comes 8 accepts later as (row 2, col 0).
        send(0, 1'b1);
        for (int px = 1; px <= 9; px++) send(px, 1'b0);
        send(10, 1'b1);
        for (int px = 1; px <= 8; px++) send(px, 1'b0);
        chk("rs_m_valid", 32'(m_valid), 32'd1);
        chk("rs_m_row", 32'(m_row), 32'd2);
        chk("rs_m_col", 32'(m_col), 32'd0);
        for (int px = 9; px <= 15; px++) send(px, 1'b0);
        flush();
`ifdef LINE_WINDOW_CTRL_STATS_EN
        chk("st_err_restart", 32'(err_restart), 32'd1);
`endif

        // Reset in RUN with a window pending, then a clean frame.
        send(0, 1'b1);
        for (int px = 1; px <= 9; px++) send(px, 1'b0);
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_col", 32'(m_col), 32'd0);
        chk("rst_m_row", 32'(m_row), 32'd0);
        chk("rst_m_eof", 32'(m_eof), 32'd0);
        hs0 = hs_cnt;
        for (int px = 0; px <= 15; px++) send(px, px == 0);
        flush();
        chk("post_rst_windows", 32'(hs_cnt - hs0), 32'd8);
`ifdef LINE_WINDOW_CTRL_STATS_EN
        chk("st_err_cleared", 32'(err_restart), 32'd0);
        for (int px = 0; px <= 15; px++) send(px, px == 0);
        flush();
        chk("st_frame_cnt", 32'(frame_cnt), 32'd2);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit rs, sv, sof, mr;
            rs  = ($urandom % 600) == 0;
            sv  = ($urandom % 10) < 7;
            mr  = ($urandom % 10) < 6;
            sof = md_in_frame ? (($urandom % 100) == 0) : (($urandom % 3) == 0);
            cyc(rs, sv, sof, 8'($urandom), mr);
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
- Sequencer for a shift_taps line buffer (tap_distance = IMG_WIDTH, number_of_taps = WIN_ROWS) used as the vertical window store for 2-D image filters.
- Accepts a raster pixel stream with valid/ready, and drives the buffer's clken, shiftin and sclr.
- Tracks column, row and frame state.
- Qualifies the buffer's taps output as a vertical window, with position and frame/line markers, toward the downstream filter.

Parameters:
- width, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line; equals the line buffer tap_distance.
- IMG_HEIGHT, 480, lines per frame.
- WIN_ROWS, 3, window height; equals the line buffer number_of_taps; legal range 2..IMG_HEIGHT.
- COL_W, 10, column counter width; must satisfy 2^COL_W >= IMG_WIDTH.
- ROW_W, 9, row counter width; must satisfy 2^ROW_W >= IMG_HEIGHT.

Ports:
- clock, in, 1, rising-edge clock.
- sclr, in, 1, synchronous active-high reset.
- s_valid, in, 1, input pixel valid.
- s_ready, out, 1, input pixel accepted when s_valid & s_ready.
- s_data, in, width, input pixel.
- s_sof, in, 1, start of frame; qualified by s_valid; marks pixel (0,0).
- lb_clken, out, 1, line buffer clock enable.
- lb_shiftin, out, width, line buffer data input.
- lb_sclr, out, 1, line buffer synchronous clear.
- m_valid, out, 1, window on the line buffer taps is valid.
- m_ready, in, 1, downstream accepts the window.
- m_col, out, COL_W, column of the newest pixel in the window.
- m_row, out, ROW_W, row of the newest (bottom) line in the window.
- m_sol, out, 1, window is the first of a line (m_col = 0).
- m_eol, out, 1, window is the last of a line.
- m_eof, out, 1, window is the last of the frame.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (sclr = 1): state IDLE; col = 0, row = 0; m_valid = 0, m_col = 0, m_row = 0, m_sol = 0, m_eol = 0, m_eof = 0, busy = 0; lb_sclr = 1 for that cycle. sclr overrides every other event.
- Handshake:
  - s_ready = (state != DONE) & (~m_valid | m_ready).
  - A buffer shift must never overwrite an unconsumed window, so input backpressure follows output backpressure.
  - accept = s_valid & s_ready.
  - lb_clken = accept, combinational; lb_shiftin = s_data, pass-through.
- Latency: the buffer taps update on the accept edge. m_valid and the markers are registered on that same edge, so they are aligned with the taps one cycle after accept.
- States:
  - IDLE: pixels with s_sof = 0 are accepted and dropped; lb_clken is forced 0 for them.
    - Accepted s_sof pixel: col = 1, row = 0, enter FILL, shift the pixel in.
  - FILL: accepted pixels shift in and are never output (m_valid is not set).
    - col increments; at col = IMG_WIDTH-1, col wraps to 0 and row increments.
    - Go to RUN when the accepted pixel is the last of line WIN_ROWS-2.
  - RUN: each accepted pixel sets m_valid = 1 with m_col = col, m_row = row, m_sol = (col == 0), m_eol = (col == IMG_WIDTH-1), m_eof = m_eol & (row == IMG_HEIGHT-1).
    - On the eof pixel, go to DONE.
  - DONE: one cycle with s_ready = 0; return to IDLE.
- Output release: m_valid falls when m_ready = 1 and no new accept occurs in that cycle. Markers hold while m_valid = 1 & m_ready = 0.
- s_sof in FILL or RUN (restart):
  - The pixel is accepted; lb_sclr = 1 in the same cycle.
  - The buffer clears and the pixel is written as new (0,0); state goes to FILL with col = 1, row = 0.
  - Any pending m_valid still completes its handshake.
- Boundaries:
  - Counter wrap: col wraps at IMG_WIDTH-1; row never exceeds IMG_HEIGHT-1.
  - Window count: exactly IMG_WIDTH*(IMG_HEIGHT-WIN_ROWS+1) windows per frame.
  - WIN_ROWS = 2: FILL lasts exactly one line.
  - WIN_ROWS = IMG_HEIGHT: RUN covers only the last line.
- lb_sclr: 1 only on reset or restart; never on normal frame completion. The buffer contents are overwritten by the next frame.

Optional Feature:
- Macro: LINE_WINDOW_CTRL_STATS_EN.
- Defined, adds ports:
  - frame_cnt (out, 16): increments on each DONE entry and wraps at 2^16.
  - err_restart (out, 1): sticky; set by s_sof in FILL or RUN; cleared only by sclr.
  - Both reset to 0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
(Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4, WIN_ROWS=3, width=8.)
- Reset then idle -> busy = 0, m_valid = 0, lb_sclr = 1 during the reset cycle. 5 pixels without s_sof -> lb_clken stays 0, s_ready = 1.
- Frame of 16 pixels 0..15, s_valid = 1, m_ready = 1:
  - 8 m_valid pulses, the first one cycle after pixel 8 is accepted, with m_row = 2, m_col = 0, m_sol = 1.
  - The last has m_row = 3, m_col = 3, m_eof = 1.
  - One cycle of s_ready = 0 follows, then busy = 0.
- Same frame with m_ready held 0 after the first window -> s_ready = 0 and lb_clken = 0 until m_ready = 1; markers stable; no window lost (8 total).
- s_sof asserted at pixel index 10 (RUN) -> lb_sclr = 1 that cycle; state FILL; next window appears 8 accepts later with m_row = 2, m_col = 0.
- sclr asserted mid-RUN with m_valid = 1 -> next cycle m_valid = 0, busy = 0, lb_sclr = 1; the following frame produces 8 windows.
- STATS_EN defined: two full frames -> frame_cnt = 2. One restart -> err_restart = 1, held until sclr.
